// File: rtl/mem_sequencer_pkg.sv
// Shared types for the LC-3b memory-transaction sequencer: memory op encoding,
// write lane mask for the default 16-bit datapath, and sequencer state encoding.
package mem_sequencer_pkg;

   localparam int unsigned LC3B_DATA_W = 16;
   localparam int unsigned LC3B_LANES  = LC3B_DATA_W / 8;

   typedef enum logic [2:0] {
      MOP_LDW = 3'd0,
      MOP_LDB = 3'd1,
      MOP_STW = 3'd2,
      MOP_STB = 3'd3,
      MOP_LDI = 3'd4,
      MOP_STI = 3'd5
   } lc3b_memop;

   typedef logic [LC3B_LANES-1:0] lc3b_mem_wmask;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD_A = 3'd1,
      ST_RD_B = 3'd2,
      ST_WR   = 3'd3,
      ST_RESP = 3'd4
   } mem_seq_state_e;

endpackage

// File: rtl/mem_seq_bytelane.sv
// Byte-lane steering: read lane extract with sign extension, and store byte
// replication with a one-hot write lane mask.
module mem_seq_bytelane #(
   parameter  int unsigned DATA_W = 16,
   localparam int unsigned LANES  = DATA_W / 8,
   localparam int unsigned LB     = $clog2(LANES)
) (
   input  logic [DATA_W-1:0] rdata,
   input  logic [LB-1:0]     rd_lane,
   input  logic [7:0]        wbyte,
   input  logic [LB-1:0]     wr_lane,
   output logic [DATA_W-1:0] rdata_sext_c,
   output logic [DATA_W-1:0] wdata_repl_c,
   output logic [LANES-1:0]  lane_mask_c
);

   logic [7:0] rd_byte;

   always_comb begin
      rd_byte = 8'h00;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (rd_lane == LB'(i)) rd_byte = rdata[8*i +: 8];
      end
   end

   assign rdata_sext_c = {{(DATA_W-8){rd_byte[7]}}, rd_byte};
   assign wdata_repl_c = {LANES{wbyte}};
   assign lane_mask_c  = LANES'(1) << wr_lane;

endmodule

// File: rtl/mem_sequencer.sv
// Request/response memory sequencer for word, byte and indirect loads/stores.
// Optional per-access watchdog enabled by defining MEM_SEQ_TIMEOUT_EN.
module mem_sequencer
   import mem_sequencer_pkg::*;
#(
   parameter  int unsigned DATA_W         = 16,
   parameter  int unsigned ADDR_W         = 16,
   parameter  int unsigned TIMEOUT_CYCLES = 255,
   localparam int unsigned LANES          = DATA_W / 8,
   localparam int unsigned LB             = $clog2(LANES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  lc3b_memop         req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [LANES-1:0]  mem_byte_enable,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_resp
);

   if (DATA_W < 16 || (DATA_W % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("mem_sequencer: unsupported parameter set");
   end

   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LANES - 1);

   mem_seq_state_e    state_q, state_d;
   lc3b_memop         op_q, op_d;
   logic [LB-1:0]     lane_q, lane_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic              req_ready_d, rsp_valid_d, rsp_err_d, mem_read_d, mem_write_d;
   logic [DATA_W-1:0] rsp_rdata_d, mem_wdata_d;
   logic [ADDR_W-1:0] mem_address_d, ptr_c;
   logic [LANES-1:0]  mem_byte_enable_d;

   logic [DATA_W-1:0] rdata_sext_c, wdata_repl_c;
   logic [LANES-1:0]  lane_mask_c;

`ifdef MEM_SEQ_TIMEOUT_EN
   localparam int unsigned       WAIT_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES - 1);
   logic [WAIT_W-1:0] wait_q, wait_d;
`endif

   mem_seq_bytelane #(.DATA_W(DATA_W)) u_bytelane (
      .rdata        (mem_rdata),
      .rd_lane      (lane_q),
      .wbyte        (req_wdata[7:0]),
      .wr_lane      (req_addr[LB-1:0]),
      .rdata_sext_c (rdata_sext_c),
      .wdata_repl_c (wdata_repl_c),
      .lane_mask_c  (lane_mask_c)
   );

   // Indirect pointer always addresses a whole word.
   assign ptr_c = ADDR_W'(mem_rdata) & ALIGN_MASK;

   always_comb begin
      state_d           = state_q;
      op_d              = op_q;
      lane_d            = lane_q;
      wdata_d           = wdata_q;
      req_ready_d       = 1'b0;
      rsp_valid_d       = 1'b0;
      rsp_err_d         = 1'b0;
      rsp_rdata_d       = '0;
      mem_read_d        = 1'b0;
      mem_write_d       = 1'b0;
      mem_address_d     = mem_address;
      mem_wdata_d       = '0;
      mem_byte_enable_d = '1;
`ifdef MEM_SEQ_TIMEOUT_EN
      wait_d            = '0;
`endif
      case (state_q)
         ST_IDLE: begin
            req_ready_d = 1'b1;
            if (req_valid && req_ready) begin
               op_d    = req_op;
               lane_d  = req_addr[LB-1:0];
               wdata_d = req_wdata;
               case (req_op)
                  MOP_LDW, MOP_LDI, MOP_STI: begin
                     state_d       = ST_RD_A;
                     req_ready_d   = 1'b0;
                     mem_read_d    = 1'b1;
                     mem_address_d = req_addr & ALIGN_MASK;
                  end
                  MOP_LDB: begin
                     state_d       = ST_RD_A;
                     req_ready_d   = 1'b0;
                     mem_read_d    = 1'b1;
                     mem_address_d = req_addr;
                  end
                  MOP_STW: begin
                     state_d       = ST_WR;
                     req_ready_d   = 1'b0;
                     mem_write_d   = 1'b1;
                     mem_address_d = req_addr & ALIGN_MASK;
                     mem_wdata_d   = req_wdata;
                  end
                  MOP_STB: begin
                     state_d           = ST_WR;
                     req_ready_d       = 1'b0;
                     mem_write_d       = 1'b1;
                     mem_address_d     = req_addr;
                     mem_wdata_d       = wdata_repl_c;
                     mem_byte_enable_d = lane_mask_c;
                  end
                  default: ;
               endcase
            end
         end
         ST_RD_A: begin
            if (mem_resp) begin
               case (op_q)
                  MOP_LDI: begin
                     state_d       = ST_RD_B;
                     mem_read_d    = 1'b1;
                     mem_address_d = ptr_c;
                  end
                  MOP_STI: begin
                     state_d       = ST_WR;
                     mem_write_d   = 1'b1;
                     mem_address_d = ptr_c;
                     mem_wdata_d   = wdata_q;
                  end
                  MOP_LDB: begin
                     state_d     = ST_RESP;
                     rsp_valid_d = 1'b1;
                     rsp_rdata_d = rdata_sext_c;
                  end
                  default: begin
                     state_d     = ST_RESP;
                     rsp_valid_d = 1'b1;
                     rsp_rdata_d = mem_rdata;
                  end
               endcase
            end else begin
               mem_read_d = 1'b1;
            end
         end
         ST_RD_B: begin
            if (mem_resp) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = mem_rdata;
            end else begin
               mem_read_d = 1'b1;
            end
         end
         ST_WR: begin
            if (mem_resp) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
            end else begin
               mem_write_d       = 1'b1;
               mem_wdata_d       = mem_wdata;
               mem_byte_enable_d = mem_byte_enable;
            end
         end
         ST_RESP: begin
            state_d     = ST_IDLE;
            req_ready_d = 1'b1;
         end
         default: begin
            state_d     = ST_IDLE;
            req_ready_d = 1'b1;
         end
      endcase
`ifdef MEM_SEQ_TIMEOUT_EN
      // Watchdog: a response arriving on the expiry cycle still wins.
      if ((state_q == ST_RD_A || state_q == ST_RD_B || state_q == ST_WR) && !mem_resp) begin
         if (wait_q == WAIT_LIMIT) begin
            state_d           = ST_RESP;
            rsp_valid_d       = 1'b1;
            rsp_err_d         = 1'b1;
            rsp_rdata_d       = '0;
            mem_read_d        = 1'b0;
            mem_write_d       = 1'b0;
            mem_wdata_d       = '0;
            mem_byte_enable_d = '1;
         end else begin
            wait_d = wait_q + WAIT_W'(1);
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         op_q            <= MOP_LDW;
         lane_q          <= '0;
         wdata_q         <= '0;
         req_ready       <= 1'b1;
         rsp_valid       <= 1'b0;
         rsp_err         <= 1'b0;
         rsp_rdata       <= '0;
         mem_read        <= 1'b0;
         mem_write       <= 1'b0;
         mem_address     <= '0;
         mem_wdata       <= '0;
         mem_byte_enable <= '1;
`ifdef MEM_SEQ_TIMEOUT_EN
         wait_q          <= '0;
`endif
      end else begin
         state_q         <= state_d;
         op_q            <= op_d;
         lane_q          <= lane_d;
         wdata_q         <= wdata_d;
         req_ready       <= req_ready_d;
         rsp_valid       <= rsp_valid_d;
         rsp_err         <= rsp_err_d;
         rsp_rdata       <= rsp_rdata_d;
         mem_read        <= mem_read_d;
         mem_write       <= mem_write_d;
         mem_address     <= mem_address_d;
         mem_wdata       <= mem_wdata_d;
         mem_byte_enable <= mem_byte_enable_d;
`ifdef MEM_SEQ_TIMEOUT_EN
         wait_q          <= wait_d;
`endif
      end
   end

endmodule
